uart_transmit: RTL and testbench

UART_TRANSMIT -- requirements
Module: uart_transmit

---
 rtl/uart_transmit.sv | 209 ++++++++++++++++++++
 tb/tb_uart_transmit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmit.sv
// uart_transmit
// -----------------------------------------------------------------------------
// Buffered 8N1 UART transmitter. Bytes are queued in a small FIFO and sent
// LSB first with one start bit and one stop bit. Back-to-back queued bytes
// go out with no idle gap between frames.
//
// Optional feature: define UART_TX_PARITY_EN to insert one even-parity bit
// between data bit 7 and the stop bit (11-bit frame instead of 10).
//
// Parameters
//   INPUT_CLOCK_FREQ : clk_in frequency in Hz
//   BAUD_RATE        : line rate in bits per second
//   FIFO_DEPTH       : input FIFO entries (power of two, >= 2)
//
// Ports
//   clk_in       : clock, rising edge
//   rst_in       : asynchronous active-high reset
//   data_byte_in : byte to send
//   trigger_in   : data_byte_in valid this cycle
//   ready_out    : FIFO can accept a byte this cycle
//   busy_out     : frame in progress or FIFO not empty
//   tx_wire_out  : serial line, idle high, registered
//
// Handshake: a byte is transferred on every rising edge where trigger_in and
// ready_out are both high. trigger_in while ready_out is low is ignored and
// the byte is lost. ready_out depends only on registered state.
// -----------------------------------------------------------------------------
module uart_transmit #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_byte_in,
  input  logic       trigger_in,
  output logic       ready_out,
  output logic       busy_out,
  output logic       tx_wire_out
);

  localparam int UART_BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W  = (UART_BIT_PERIOD > 1) ? $clog2(UART_BIT_PERIOD) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  LAST_CYCLE = CNT_W'(UART_BIT_PERIOD - 1);
  localparam logic [FCNT_W-1:0] DEPTH_C    = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [FCNT_W-1:0] fifo_count_q;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [7:0]        fifo_head;

  assign ready_out  = (fifo_count_q < DEPTH_C);
  assign fifo_empty = (fifo_count_q == '0);
  assign push       = trigger_in & ready_out;
  assign fifo_head  = fifo_mem[rd_ptr_q];

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + FCNT_W'(1);
        2'b01:   fifo_count_q <= fifo_count_q - FCNT_W'(1);
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr_q] <= data_byte_in;
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic             tx_q, tx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       data_q, data_d;
  logic             bit_done;
  logic [2:0]       bit_idx_nxt;

  assign bit_done    = (cnt_q == LAST_CYCLE);
  assign bit_idx_nxt = 3'(bit_idx_q + 3'd1);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      tx_q      <= 1'b1;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    cnt_d     = bit_done ? '0 : cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    pop       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_d  = fifo_head;
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (bit_done) begin
          bit_idx_d = '0;
          tx_d      = data_q[0];
          state_d   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (bit_done) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = ^data_q;
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_nxt;
            tx_d      = data_q[bit_idx_nxt];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (bit_done) begin
          // Chain straight into the next start bit when a byte is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            data_d  = fifo_head;
            tx_d    = 1'b0;
            state_d = ST_START;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign tx_wire_out = tx_q;
  assign busy_out    = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_transmit.sv
// tb_uart_transmit
// Bench for uart_transmit with INPUT_CLOCK_FREQ=1000, BAUD_RATE=100
// (10 cycles per bit) and FIFO_DEPTH=4. A frame-level reference model
// predicts accepted bytes, busy/ready and the line level each cycle; a
// monitor decodes frames off the line and checks them against exp_q.
module tb_uart_transmit;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DEPTH  = 4;
  localparam int P      = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = NB * P;

  logic       clk_in;
  logic       rst_in;
  logic [7:0] data_byte_in;
  logic       trigger_in;
  logic       ready_out;
  logic       busy_out;
  logic       tx_wire_out;

  uart_transmit #(
    .INPUT_CLOCK_FREQ(CLK_HZ),
    .BAUD_RATE       (BAUD),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .data_byte_in(data_byte_in),
    .trigger_in  (trigger_in),
    .ready_out   (ready_out),
    .busy_out    (busy_out),
    .tx_wire_out (tx_wire_out)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // ---------------- scoreboard state ----------------
  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  bit         chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_q: bytes waiting; m_rem: cycles of the current frame still to go;
  // m_cur: byte of the current frame.
  logic [7:0] m_q[$];
  int         m_rem = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_acc;
  bit         m_pop;

  function automatic logic exp_line(input int r, input logic [7:0] b);
    int idx;
    if (r == 0) return 1'b1;
    idx = (F - r) / P;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == NB - 1) return 1'b1;
    return ^b;
  endfunction

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      m_q.delete();
      exp_q.delete();
      m_rem = 0;
    end else begin
      m_acc = trigger_in && (m_q.size() < DEPTH);
      m_pop = (m_q.size() > 0) && (m_rem <= 1);
      if (m_pop) begin
        m_cur = m_q.pop_front();
        m_rem = F;
      end else if (m_rem > 0) begin
        m_rem = m_rem - 1;
      end
      if (m_acc) begin
        m_q.push_back(data_byte_in);
        exp_q.push_back(data_byte_in);
      end
    end
  end

  // Per-cycle comparison of registered outputs against the model.
  always @(negedge clk_in) begin
    if (chk_en && !rst_in) begin
      check("busy", 32'(busy_out), 32'((m_rem > 0) || (m_q.size() > 0)));
      check("ready", 32'(ready_out), 32'(m_q.size() < DEPTH));
      check("line", 32'(tx_wire_out), 32'(exp_line(m_rem, m_cur)));
    end
  end

  // ---------------- monitor: decode frames off the line ----------------
  bit            mon_act = 0;
  int            mon_cnt = 0;
  logic [NB-1:0] mon_bits;

  task automatic frame_check();
    logic [7:0] b;
    b = mon_bits[8:1];
    check("start_bit", 32'(mon_bits[0]), 32'(0));
    check("stop_bit", 32'(mon_bits[NB-1]), 32'(1));
`ifdef UART_TX_PARITY_EN
    check("parity_bit", 32'(mon_bits[9]), 32'(^b));
`endif
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL frame_unexpected t=%0t got=%0h want=none", $time, b);
    end else begin
      check("frame_byte", 32'(b), 32'(exp_q.pop_front()));
    end
  endtask

  always @(negedge clk_in) begin
    if (rst_in) begin
      mon_act = 0;
    end else begin
      if (!mon_act && tx_wire_out == 1'b0) begin
        mon_act = 1;
        mon_cnt = 0;
      end
      if (mon_act) begin
        if (mon_cnt % P == P / 2) mon_bits[mon_cnt / P] = tx_wire_out;
        if (mon_cnt == (NB - 1) * P + P / 2) begin
          mon_act = 0;
          frame_check();
        end
        mon_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic t, input logic [7:0] d);
    trigger_in   = t;
    data_byte_in = d;
    @(negedge clk_in);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_rem != 0 || m_q.size() != 0) && n < 5000) begin
      drive(1'b0, 8'h00);
      n++;
    end
    check("drain_in_time", 32'(n < 5000), 32'(1));
    idle(5);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_in       = 1'b1;
    trigger_in   = 1'b0;
    data_byte_in = 8'h00;
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_tx", 32'(tx_wire_out), 32'(1));
    check("reset_ready", 32'(ready_out), 32'(1));
    check("reset_busy", 32'(busy_out), 32'(0));
    @(posedge clk_in);
    #3 rst_in = 1'b0;
    @(negedge clk_in);
    chk_en = 1;

    // Single byte from idle.
    drive(1'b1, 8'hA5);
    idle(F + 20);

    // Odd-parity data byte.
    drive(1'b1, 8'h07);
    drain();

    // Six pushes on consecutive edges: the sixth is dropped.
    for (int i = 0; i < 6; i++) drive(1'b1, 8'($urandom_range(0, 255)));
    drain();

    // Two pushes two cycles apart: frames must chain.
    drive(1'b1, 8'h3C);
    drive(1'b0, 8'h00);
    drive(1'b1, 8'hC3);
    drain();

    // Random traffic.
    for (int i = 0; i < 1500; i++)
      drive(1'($urandom_range(0, 29) == 0), 8'($urandom_range(0, 255)));
    drain();

    // Reset during bit 3 with two bytes queued.
    drive(1'b1, 8'h11);
    drive(1'b1, 8'h22);
    drive(1'b1, 8'h33);
    idle(45);
    @(posedge clk_in);
    #3 rst_in = 1'b1;
    #1;
    check("midrst_tx", 32'(tx_wire_out), 32'(1));
    check("midrst_busy", 32'(busy_out), 32'(0));
    check("midrst_ready", 32'(ready_out), 32'(1));
    repeat (3) @(posedge clk_in);
    #3 rst_in = 1'b0;
    @(negedge clk_in);
    idle(3 * F);
    drain();

    check("frames_outstanding", 32'(exp_q.size()), 32'(0));
    check("monitor_idle", 32'(mon_act), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
